// File: rtl/echo_delay_if.sv
// Sample/control bus between the audio sample source and echo_delay.
// master = sample source side, slave = echo_delay side.
interface echo_delay_if #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned AMT_W  = 5
);
    logic                     ready;
    logic signed [WIDTH-1:0]  incoming_sample;
    logic [AMT_W-1:0]         delay_amount;
    logic [3:0]               mix;
    logic [3:0]               feedback;
    logic signed [WIDTH-1:0]  modified_sample;
    logic                     done;
    logic [ADDR_W-1:0]        current_pointer;
    logic [ADDR_W-1:0]        delayed_pointer;

    modport master (
        output ready, incoming_sample, delay_amount, mix, feedback,
        input  modified_sample, done, current_pointer, delayed_pointer
    );

    modport slave (
        input  ready, incoming_sample, delay_amount, mix, feedback,
        output modified_sample, done, current_pointer, delayed_pointer
    );
endinterface

// File: rtl/echo_delay.sv
// Circular-buffer echo: y = sat(x + (d*mix)>>>4), buffer write-back w optionally includes feedback.
// Optional feature macro: ECHO_DELAY_FEEDBACK_EN (undefined: feedback port ignored, w = x).
module echo_delay #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned AMT_W  = 5,
    parameter int unsigned STEP   = 256
) (
    input  logic         clock,
    input  logic         reset,
    echo_delay_if.slave  bus
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned CW     = WIDTH + 5;
    localparam int unsigned FILL_W = ADDR_W + 1;

    localparam logic signed [CW-1:0] SAT_MAX = CW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CALC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nx;
    logic   w_latch;
    logic   w_mem_re;
    logic   w_calc;
    logic   w_mem_we;

    logic signed [WIDTH-1:0] r_mem [DEPTH];
    logic signed [WIDTH-1:0] r_rd_data;
    logic signed [WIDTH-1:0] r_x;
    logic [ADDR_W-1:0]       r_d;
    logic [3:0]              r_mix;
    logic [ADDR_W-1:0]       r_cptr;
    logic [ADDR_W-1:0]       r_dptr;
    logic [FILL_W-1:0]       r_fill;
    logic signed [CW-1:0]    r_wet;
    logic signed [CW-1:0]    r_fbv;
    logic signed [WIDTH-1:0] r_y;
    logic                    r_done;

    logic [31:0]             w_d_full;
    logic [ADDR_W-1:0]       w_d;
    logic signed [WIDTH-1:0] w_dval;
    logic signed [CW-1:0]    w_dext;
    logic signed [CW-1:0]    w_wet;
    logic signed [CW-1:0]    w_fb;
    logic signed [WIDTH-1:0] w_y;
    logic signed [WIDTH-1:0] w_wr_data;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [CW-1:0] v);
        if (v > SAT_MAX) return WIDTH'(SAT_MAX);
        if (v < SAT_MIN) return WIDTH'(SAT_MIN);
        return WIDTH'(v);
    endfunction

    // Delay in samples, clamped so the read never aliases the write location
    assign w_d_full = 32'(bus.delay_amount) * 32'(STEP);
    assign w_d      = (w_d_full > 32'(DEPTH - 1)) ? ADDR_W'(DEPTH - 1) : ADDR_W'(w_d_full);

    // Locations not yet written since reset (or bypass) contribute nothing
    assign w_dval = ((r_fill < {1'b0, r_d}) || (r_d == '0)) ? '0 : r_rd_data;
    assign w_dext = CW'(w_dval);
    assign w_wet  = (w_dext * CW'($signed({1'b0, r_mix}))) >>> 4;

`ifdef ECHO_DELAY_FEEDBACK_EN
    logic [3:0] r_fbg;
    assign w_fb = (w_dext * CW'($signed({1'b0, r_fbg}))) >>> 4;

    always_ff @(posedge clock) begin
        if (reset)        r_fbg <= '0;
        else if (w_latch) r_fbg <= bus.feedback;
    end
`else
    logic w_unused_feedback;
    assign w_unused_feedback = ^bus.feedback;
    assign w_fb = '0;
`endif

    assign w_y       = sat(CW'(r_x) + r_wet);
    assign w_wr_data = sat(CW'(r_x) + r_fbv);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_latch    = 1'b0;
        w_mem_re   = 1'b0;
        w_calc     = 1'b0;
        w_mem_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ready) begin
                    w_latch    = 1'b1;
                    w_state_nx = S_READ;
                end
            end
            S_READ: begin
                w_mem_re   = 1'b1;
                w_state_nx = S_CALC;
            end
            S_CALC: begin
                w_calc     = 1'b1;
                w_state_nx = S_WRITE;
            end
            S_WRITE: begin
                w_mem_we   = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Sample buffer: contents deliberately not reset
    always_ff @(posedge clock) begin
        if (w_mem_we && !reset) r_mem[r_cptr] <= w_wr_data;
        if (w_mem_re)           r_rd_data     <= r_mem[r_dptr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_x    <= '0;
            r_d    <= '0;
            r_mix  <= '0;
            r_cptr <= '0;
            r_dptr <= '0;
            r_fill <= '0;
            r_wet  <= '0;
            r_fbv  <= '0;
            r_y    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_latch) begin
                r_x    <= bus.incoming_sample;
                r_d    <= w_d;
                r_mix  <= bus.mix;
                r_dptr <= r_cptr - w_d;
            end
            if (w_calc) begin
                r_wet <= w_wet;
                r_fbv <= w_fb;
            end
            if (w_mem_we) begin
                r_y    <= w_y;
                r_done <= 1'b1;
                r_cptr <= r_cptr + ADDR_W'(1);
                r_dptr <= r_cptr + ADDR_W'(1) - r_d;
                if (r_fill != FILL_W'(DEPTH)) r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    assign bus.modified_sample = r_y;
    assign bus.done            = r_done;
    assign bus.current_pointer = r_cptr;
    assign bus.delayed_pointer = r_dptr;

endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay: reset, bypass, busy strobe, echo, feedback, saturation, fill and wrap.
module tb_echo_delay;

    localparam int unsigned WIDTH  = 12;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned AMT_W  = 5;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    echo_delay_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AMT_W(AMT_W)) bus ();

    echo_delay #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AMT_W(AMT_W), .STEP(256)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after done should have risen
    task automatic do_sample(input int x, input int exp_y, input string tag, input int n);
        logic [3:0] pat;
        pat = '0;
        bus.incoming_sample = WIDTH'(x);
        bus.ready = 1'b1;
        @(negedge clock);
        bus.ready = 1'b0;
        pat = {pat[2:0], bus.done};
        repeat (3) begin
            @(negedge clock);
            pat = {pat[2:0], bus.done};
        end
        check_eq($sformatf("%s_done[%0d]", tag, n), 32'(pat), 32'd1);
        check_eq($sformatf("%s_y[%0d]", tag, n), 32'(bus.modified_sample), exp_y);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_ctrl(input int amt, input int mx, input int fbk);
        bus.delay_amount = AMT_W'(amt);
        bus.mix          = 4'(mx);
        bus.feedback     = 4'(fbk);
    endtask

    initial begin
        logic [6:0] busy_pat;
        logic       any_done;
        int         x;
        int         ey;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.ready = 1'b0;
        bus.incoming_sample = '0;
        set_ctrl(0, 0, 0);

        do_reset();
        check_eq("rst_y",    32'(bus.modified_sample), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_cptr", 32'(bus.current_pointer), 0);
        check_eq("rst_dptr", 32'(bus.delayed_pointer), 0);

        // Bypass
        set_ctrl(0, 8, 0);
        do_sample(-37, -37, "bypass", 0);
        check_eq("bypass_cptr", 32'(bus.current_pointer), 1);

        // Second ready while busy is ignored
        bus.incoming_sample = WIDTH'(55);
        bus.ready = 1'b1;
        busy_pat = '0;
        @(negedge clock);
        bus.incoming_sample = WIDTH'(77);
        busy_pat = {busy_pat[5:0], bus.done};
        @(negedge clock);
        bus.ready = 1'b0;
        busy_pat = {busy_pat[5:0], bus.done};
        repeat (5) begin
            @(negedge clock);
            busy_pat = {busy_pat[5:0], bus.done};
            if (busy_pat[0]) check_eq("busy_y", 32'(bus.modified_sample), 55);
        end
        check_eq("busy_done_pat", 32'(busy_pat), 32'(7'b0001000));
        check_eq("busy_cptr", 32'(bus.current_pointer), 2);

        // Reset during READ abandons the operation
        bus.incoming_sample = WIDTH'(300);
        bus.ready = 1'b1;
        @(negedge clock);
        bus.ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_eq("midrst_done_a", 32'(bus.done), 0);
        @(negedge clock);
        reset = 1'b0;
        check_eq("midrst_y",    32'(bus.modified_sample), 0);
        check_eq("midrst_done", 32'(bus.done), 0);
        check_eq("midrst_cptr", 32'(bus.current_pointer), 0);
        any_done = 1'b0;
        repeat (4) begin
            @(negedge clock);
            any_done = any_done | bus.done;
        end
        check_eq("midrst_no_done", 32'(any_done), 0);
        check_eq("midrst_cptr2", 32'(bus.current_pointer), 0);
        do_sample(12, 12, "post_rst", 0);
        check_eq("post_rst_cptr", 32'(bus.current_pointer), 1);

        // Single echo: impulse 1000, delay 256, mix 8/16
        do_reset();
        set_ctrl(1, 8, 0);
        for (int n = 0; n <= 600; n++) begin
            x  = (n == 0) ? 1000 : 0;
            ey = (n == 0) ? 1000 : (n == 256) ? 500 : 0;
            do_sample(x, ey, "echo", n);
            if (n == 0) begin
                check_eq("echo_cptr0", 32'(bus.current_pointer), 1);
                check_eq("echo_dptr0", 32'(bus.delayed_pointer), 7937);
            end
        end
        check_eq("echo_cptr600", 32'(bus.current_pointer), 601);
        check_eq("echo_dptr600", 32'(bus.delayed_pointer), 345);

        // Feedback: decaying repeats only when the feature is built in
        do_reset();
        set_ctrl(1, 8, 8);
        for (int n = 0; n <= 768; n++) begin
            x = (n == 0) ? 1000 : 0;
`ifdef ECHO_DELAY_FEEDBACK_EN
            ey = (n == 0) ? 1000 : (n == 256) ? 500 : (n == 512) ? 250 : (n == 768) ? 125 : 0;
`else
            ey = (n == 0) ? 1000 : (n == 256) ? 500 : 0;
`endif
            do_sample(x, ey, "fbk", n);
        end

        // Saturation, positive then negative
        do_reset();
        set_ctrl(1, 15, 0);
        for (int n = 0; n <= 256; n++) begin
            x  = (n == 0 || n == 256) ? 2000 : 0;
            ey = (n == 0) ? 2000 : (n == 256) ? 2047 : 0;
            do_sample(x, ey, "satp", n);
        end
        do_reset();
        for (int n = 0; n <= 256; n++) begin
            x  = (n == 0 || n == 256) ? -2000 : 0;
            ey = (n == 0) ? -2000 : (n == 256) ? -2048 : 0;
            do_sample(x, ey, "satn", n);
        end

        // Longest delay over a stale buffer, running across the pointer wrap
        do_reset();
        set_ctrl(31, 8, 0);
        for (int n = 0; n < 8200; n++) begin
            x  = (n % 64) - 32;
            ey = (n < 7936) ? x : x + (x >>> 1);
            do_sample(x, ey, "fill", n);
            if (n == 8191) check_eq("wrap_cptr", 32'(bus.current_pointer), 0);
        end
        check_eq("wrap_cptr_end", 32'(bus.current_pointer), 8);
        check_eq("wrap_dptr_end", 32'(bus.delayed_pointer), 264);

        // Bypass again with a full buffer
        set_ctrl(0, 15, 0);
        do_sample(-37, -37, "bypass2", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
